// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the issue/hazard scheduler
// Contents:
//   NOP_INSTR      encoding placed into ID/EX on a bubble
//   sched_state_t  issue FSM states {RUN, SHADOW}
//   sb_slot_t      one scoreboard entry {valid, dst}
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0041_0020;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
  } sb_slot_t;

endpackage

// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - IF/ID side signal bundle of the issue scheduler
// Signals:
//   pc_ld, id_valid, rs, rt, rs_used, rt_used, dst, dst_wr, is_branch, br_taken
//                           decoded-instruction and pipeline control inputs
//   issue, stall, flush     per-cycle scheduling decision
//   stall_cnt               saturating stall-cycle counter (CNT_W bits)
// Modports: master drives the instruction side, slave is the scheduler.
interface hazard_sched_if #(
  parameter int CNT_W = 16
) ();

  logic             pc_ld;
  logic             id_valid;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_used;
  logic             rt_used;
  logic [4:0]       dst;
  logic             dst_wr;
  logic             is_branch;
  logic             br_taken;
  logic             issue;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output pc_ld, id_valid, rs, rt, rs_used, rt_used, dst, dst_wr, is_branch, br_taken,
    input  issue, stall, flush, stall_cnt
  );

  modport slave (
    input  pc_ld, id_valid, rs, rt, rs_used, rt_used, dst, dst_wr, is_branch, br_taken,
    output issue, stall, flush, stall_cnt
  );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - compare one source register against the three scoreboard slots
// Ports:
//   i_src    source register number
//   i_used   instruction actually reads i_src
//   i_slots  scoreboard slots, [0]=EX [1]=MEM [2]=WR
//   o_hit    i_src is pending in a valid slot ($0 never matches)
module sb_match
  import pipe_pkg::*;
(
  input  logic           i_src_used_dummy_unused_n,
  input  logic [4:0]     i_src,
  input  logic           i_used,
  input  sb_slot_t [2:0] i_slots,
  output logic           o_hit
);

  logic w_unused;
  assign w_unused = i_src_used_dummy_unused_n;

  // WR slot is included: the register file does not forward a same-cycle write.
  always_comb begin
    o_hit = 1'b0;
    if (i_used && (i_src != 5'd0)) begin
      for (int i = 0; i < 3; i++) begin
        if (i_slots[i].valid && (i_slots[i].dst == i_src)) begin
          o_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - IF/ID issue controller: RAW scoreboard, branch shadow, flush
// Ports:
//   clk   pipeline clock
//   arst  asynchronous active-high reset
//   bus   hazard_sched_if.slave: instruction inputs, issue/stall/flush/stall_cnt outputs
// Parameters:
//   BR_SHADOW  stall cycles after a branch issues (fits the 2-bit shadow counter)
//   CNT_W      stall counter width, must match the interface
module hazard_sched
  import pipe_pkg::*;
#(
  parameter int BR_SHADOW = 3,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          arst,
  hazard_sched_if.slave bus
);

  sb_slot_t [2:0]   r_slot;
  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [1:0]       r_bcnt;
  logic [1:0]       w_bcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_hazard;
  logic             w_issue;
  logic             w_stall;
  logic             w_flush;

  sb_match u_rs_match (
    .i_src_used_dummy_unused_n (1'b0),
    .i_src                     (bus.rs),
    .i_used                    (bus.rs_used),
    .i_slots                   (r_slot),
    .o_hit                     (w_rs_hit)
  );

  sb_match u_rt_match (
    .i_src_used_dummy_unused_n (1'b0),
    .i_src                     (bus.rt),
    .i_used                    (bus.rt_used),
    .i_slots                   (r_slot),
    .o_hit                     (w_rt_hit)
  );

  assign w_hazard = w_rs_hit | w_rt_hit;

  // Priority: reset, pc_ld, shadow, data hazard, issue.
  always_comb begin
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    if (arst) begin
      w_state_nxt = RUN;
      w_bcnt_nxt  = 2'd0;
    end else if (bus.pc_ld) begin
      w_state_nxt = RUN;
      w_bcnt_nxt  = 2'd0;
    end else if (r_state == SHADOW) begin
      w_stall    = 1'b1;
      w_bcnt_nxt = r_bcnt - 2'd1;
      // bcnt==2 is the cycle the branch sits in MEM and br_taken is meaningful.
      if ((r_bcnt == 2'd2) && bus.br_taken) begin
        w_flush = 1'b1;
      end
      if (r_bcnt == 2'd1) begin
        w_state_nxt = RUN;
      end
    end else if (bus.id_valid && w_hazard) begin
      w_stall = 1'b1;
    end else if (bus.id_valid) begin
      w_issue = 1'b1;
      if (bus.is_branch) begin
        w_state_nxt = SHADOW;
        w_bcnt_nxt  = 2'(BR_SHADOW);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= RUN;
      r_bcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Slots always shift; a non-issuing cycle loads an invalid entry, which is
  // what lets a hazard drain without any extra bookkeeping.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_slot <= '0;
    end else if (bus.pc_ld) begin
      r_slot <= '0;
    end else begin
      r_slot[2]       <= r_slot[1];
      r_slot[1]       <= r_slot[0];
      r_slot[0].valid <= w_issue & bus.dst_wr & (bus.dst != 5'd0);
      r_slot[0].dst   <= bus.dst;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.issue     = w_issue;
  assign bus.stall     = w_stall;
  assign bus.flush     = w_flush;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - directed self-checking bench for hazard_sched
module tb_hazard_sched;

  logic clk;
  logic arst;
  int   total;
  int   bad;

  hazard_sched_if #(.CNT_W(4)) bus ();

  hazard_sched #(
    .BR_SHADOW (3),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic iss, input logic stl, input logic fl);
    chk({tag, ".issue"}, {31'd0, bus.issue}, {31'd0, iss});
    chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, stl});
    chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
  endtask

  task automatic cnt(input string tag, input logic [3:0] exp);
    chk({tag, ".stall_cnt"}, {28'd0, bus.stall_cnt}, {28'd0, exp});
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                       input logic dw, input logic br);
    bus.id_valid  = v;
    bus.rs        = rs;
    bus.rs_used   = rsu;
    bus.rt        = rt;
    bus.rt_used   = rtu;
    bus.dst       = dst;
    bus.dst_wr    = dw;
    bus.is_branch = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    arst          = 1'b1;
    bus.pc_ld     = 1'b0;
    bus.br_taken  = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    outs("reset", 1'b0, 1'b0, 1'b0);
    cnt("reset", 4'd0);
    step();
    step();
    arst = 1'b0;

    // Back-to-back RAW on r5: three bubbles, then issue.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    smp(); outs("raw.c0", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    smp(); outs("raw.c1", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("raw.c2", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("raw.c3", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("raw.c4", 1'b1, 1'b0, 1'b0);
    cnt("raw.c4", 4'd3);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(); step(); step();

    // $0 writes are never tracked.
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    smp(); outs("r0.c0", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    smp(); outs("r0.c1", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(); step(); step();

    // Distance 3 on rt hits the WR slot: one bubble. Unused rs=7 is ignored.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    smp(); outs("d3.a", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp(); outs("d3.b", 1'b1, 1'b0, 1'b0);
    step();
    smp(); outs("d3.c", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    smp(); outs("d3.d", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("d3.e", 1'b1, 1'b0, 1'b0);
    cnt("d3.e", 4'd4);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(); step(); step();

    // Taken branch, br_taken held high from t+2: flush only at t+2.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    smp(); outs("brA.t0", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp(); outs("brA.t1", 1'b0, 1'b1, 1'b0);
    step();
    bus.br_taken = 1'b1;
    smp(); outs("brA.t2", 1'b0, 1'b1, 1'b1);
    step();
    smp(); outs("brA.t3", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("brA.t4", 1'b1, 1'b0, 1'b0);
    cnt("brA.t4", 4'd7);
    step();
    bus.br_taken = 1'b0;

    // br_taken at t+1 and t+3 only: never flushes.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    smp(); outs("brB.t0", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.br_taken = 1'b1;
    smp(); outs("brB.t1", 1'b0, 1'b1, 1'b0);
    step();
    bus.br_taken = 1'b0;
    smp(); outs("brB.t2", 1'b0, 1'b1, 1'b0);
    step();
    bus.br_taken = 1'b1;
    smp(); outs("brB.t3", 1'b0, 1'b1, 1'b0);
    step();
    smp(); outs("brB.t4", 1'b0, 1'b0, 1'b0);
    cnt("brB.t4", 4'd10);
    step();
    bus.br_taken = 1'b0;

    // pc_ld beats a pending hazard and br_taken, and clears the scoreboard.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    smp(); outs("pcld.a", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.pc_ld    = 1'b1;
    bus.br_taken = 1'b1;
    smp(); outs("pcld.b", 1'b0, 1'b0, 1'b0);
    step();
    bus.pc_ld    = 1'b0;
    bus.br_taken = 1'b0;
    smp(); outs("pcld.c", 1'b1, 1'b0, 1'b0);
    cnt("pcld.c", 4'd10);
    step();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();

    // Asynchronous reset in the middle of a branch shadow.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    smp(); outs("ar.t0", 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    smp(); outs("ar.t2", 1'b0, 1'b1, 1'b0);
    cnt("ar.t2", 4'd11);
    #1 arst = 1'b1;
    #1;
    outs("ar.during", 1'b0, 1'b0, 1'b0);
    cnt("ar.during", 4'd0);
    step();
    arst = 1'b0;
    smp(); outs("ar.after", 1'b1, 1'b0, 1'b0);
    cnt("ar.after", 4'd0);
    step();

    // Saturation: back-to-back branches give issue,stall,stall,stall per 4 cycles.
    // The loop below starts one cycle after the previous issue left cnt at 0.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    smp(); outs("sat.t0", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    smp(); cnt("sat.16", 4'd12);
    for (int i = 0; i < 8; i++) step();
    smp(); cnt("sat.24", 4'd15);
    for (int i = 0; i < 4; i++) step();
    smp(); cnt("sat.28", 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Issue controller for the 5-stage pipelined CPU. Sits at the IF/ID boundary and decides each cycle whether the decoded instruction issues or is replaced by the pipeline NOP. It tracks in-flight register writes in a 3-slot scoreboard (EX, MEM, WR) and enforces the fixed 3-cycle branch shadow. It replaces the per-instruction compare chain with one sequenced unit that drives PC hold, bubble insertion and flush.

## Interface
Parameters:
- `NOP_INSTR`, 32'h0041_0020: encoding inserted on a bubble.
- `BR_SHADOW`, 3: cycles held after a branch issues.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `pc_ld`  in  1  PC load in progress; synchronous clear of all scheduling state.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `rs`, `rt`  in  5 each  source register numbers.
- `rs_used`, `rt_used`  in  1 each  the instruction reads that source.
- `dst`  in  5  destination register number.
- `dst_wr`  in  1  the instruction writes `dst`.
- `is_branch`  in  1  the instruction is a branch (beq, bne, bgtz).
- `br_taken`  in  1  branch taken, valid from the MEM stage.
- `issue`  out  1  instruction accepted into ID/EX this cycle.
- `stall`  out  1  hold PC and IF/ID; ID/EX receives `NOP_INSTR`.
- `flush`  out  1  discard IF/ID contents, because a taken branch redirected the PC.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1.

## Operation
- Scoreboard:
  - Three slots: S0 = EX, S1 = MEM, S2 = WR. Each slot holds {valid, dst}.
  - Every cycle the slots shift: S2←S1, S1←S0.
  - S0 loads {1, `dst`} when `issue`, `dst_wr` and `dst`≠0. Otherwise S0 loads invalid.
- Data hazard:
  - Source `rs` matches when `rs_used`, `rs`≠0 and `rs` equals the dst of any valid slot. Source `rt` matches the same way with `rt_used`.
  - The hazard is active when `rs` or `rt` matches.
  - The register file is not write-through, so the WR slot counts as a match.
- FSM states: RUN and SHADOW. A 2-bit counter `bcnt` runs while in SHADOW.
  - RUN → SHADOW when a branch issues; `bcnt` is loaded with BR_SHADOW.
  - In SHADOW, `stall`=1 and `issue`=0. `bcnt` decrements each cycle, and the FSM returns to RUN after the cycle in which `bcnt`=1.
  - `br_taken` is sampled only in SHADOW with `bcnt`=2 (the branch is in MEM). When set, `flush`=1 for that cycle only.
  - `br_taken` is ignored in every other cycle.
- Output priority, highest first:
  - `pc_ld`: `issue`=0, `stall`=0, `flush`=0. Scoreboard cleared, FSM → RUN, `bcnt`=0.
  - SHADOW: `stall`=1.
  - RUN with hazard and `id_valid`: `stall`=1, `issue`=0.
  - RUN with `id_valid` and no hazard: `issue`=1.
  - Otherwise: all outputs 0.
- `stall_cnt` increments when `stall`=1, saturates at all-ones, and clears only on `arst`.
- Reset: `issue`, `stall` and `flush` are 0. All slots are invalid, FSM = RUN, `bcnt`=0, `stall_cnt`=0.

## Timing
- `issue`, `stall` and `flush` are combinational from the current state and ID inputs. The state registers are updated at the edge.
- Data dependency on the immediately preceding instruction gives 3 bubble cycles (dependency in S0, then S1, then S2). Distance 2 gives 2 bubbles, distance 3 gives 1, and distance 4 or more gives none.
- A branch issued in cycle t is followed by `stall`=1 in t+1..t+3, with the next issue possible in t+4. `flush` can assert only in t+2.
- Because bubbles shift in as invalid, a hazard clears without extra state.
- `arst` asserted mid-shadow or mid-hazard takes effect immediately, asynchronously. Outputs return to their reset values.
- `pc_ld` and `br_taken` in the same cycle: `pc_ld` wins and no flush is issued.
- A branch with `dst_wr`=0 does not occupy a scoreboard slot.

## Structure
- Package `pipe_pkg` holds:
  - `NOP_INSTR`.
  - The FSM state enum {RUN, SHADOW}.
  - The scoreboard slot struct {valid, dst[4:0]}.
- Sub-module `sb_match`: combinational compare of one 5-bit source against the 3 slots, instantiated twice (`rs`, `rt`).
- Top-level contents: FSM, `bcnt`, slot shift register, priority logic, `stall_cnt`.

## Test plan
- **Back-to-back RAW:** issue `add` with `dst`=5, then present `rs`=5 with `rs_used`=1 → `stall`=1 for 3 cycles, then `issue`=1; `stall_cnt`=3.
- **Register $0 exempt:** issue with `dst`=0, `dst_wr`=1, then `rs`=0 with `rs_used` → `issue`=1 with no stall.
- **Taken branch:** issue `beq` at t, with `br_taken`=1 at t+2 → `stall`=1 at t+1..t+3, `flush`=1 only at t+2, `issue` possible at t+4. Repeating with `br_taken`=1 at t+1 and at t+3 gives no flush.
- **`pc_ld` priority:** hazard pending in S1, `pc_ld`=1 with `br_taken`=1 → `flush`=0 and scoreboard cleared. Next cycle, `rs` matching the old dst → `issue`=1.
- **Async reset mid-shadow:** assert `arst` at t+2 of a shadow → outputs 0 immediately. After release, the FSM is in RUN and `stall_cnt`=0.
- **Saturation:** with `CNT_W`=4, force 20 stall cycles → `stall_cnt` holds at 15.
